sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce.sv | 123 ++++++++++++
 tb/tb_sw_debounce.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// Vector switch debouncer: 2-flop synchronizer, stability counter FSM and a single-entry
// valid/ready event register that overwrites (and flags overrun) when not drained in time.
module sw_debounce #(
    parameter int unsigned NB_SW      = 4,
    parameter int unsigned NB_COUNTER = 14,
    parameter int unsigned N_STABLE   = 10000
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic [NB_SW-1:0] i_sw,
    input  logic             i_ready,
    output logic [NB_SW-1:0] o_sw,
    output logic [NB_SW-1:0] o_rise,
    output logic [NB_SW-1:0] o_fall,
    output logic             o_valid,
    output logic [NB_SW-1:0] o_event,
    output logic             o_overrun
);

    typedef enum logic [1:0] {StStable, StCount, StCommit} state_e;

    localparam logic [NB_COUNTER-1:0] CntLast = NB_COUNTER'(N_STABLE - 1);

    state_e                r_state, w_state_next;
    logic [NB_SW-1:0]      r_meta, r_sync;
    logic [NB_SW-1:0]      r_cand, w_cand_next;
    logic [NB_COUNTER-1:0] r_cnt, w_cnt_next;
    logic [NB_SW-1:0]      r_sw, r_rise, r_fall, r_event;
    logic                  r_valid, r_overrun;
    logic                  w_commit, w_xfer, w_overrun;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_sw;
            r_sync <= r_meta;
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= StStable;
            r_cand  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cand  <= w_cand_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // A return to the committed value always wins over a new candidate (bounce rejected).
    always_comb begin
        w_state_next = r_state;
        w_cand_next  = r_cand;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            StStable: begin
                if (r_sync != r_sw) begin
                    w_cand_next  = r_sync;
                    w_cnt_next   = '0;
                    w_state_next = StCount;
                end
            end
            StCount: begin
                if (r_sync == r_sw) begin
                    w_state_next = StStable;
                end else if (r_sync != r_cand) begin
                    w_cand_next = r_sync;
                    w_cnt_next  = '0;
                end else if (r_cnt == CntLast) begin
                    w_state_next = StCommit;
                end else begin
                    w_cnt_next = r_cnt + NB_COUNTER'(1);
                end
            end
            StCommit: w_state_next = StStable;
            default:  w_state_next = StStable;
        endcase
    end

    always_comb begin
        w_commit  = (r_state == StCommit);
        w_xfer    = r_valid & i_ready;
        w_overrun = w_commit & r_valid & ~i_ready;
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sw      <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_event   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_overrun;
            if (w_commit) begin
                r_sw    <= r_cand;
                r_rise  <= r_cand & ~r_sw;
                r_fall  <= ~r_cand & r_sw;
                r_event <= r_cand;
                r_valid <= 1'b1;
            end else begin
                r_rise <= '0;
                r_fall <= '0;
                if (w_xfer) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign o_sw      = r_sw;
    assign o_rise    = r_rise;
    assign o_fall    = r_fall;
    assign o_valid   = r_valid;
    assign o_event   = r_event;
    assign o_overrun = r_overrun;

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce (NB_SW=4, N_STABLE=4): stimulus queues the expected commit,
// a negedge monitor pops and compares whenever the DUT emits rise/fall pulses.
module tb_sw_debounce;

    logic       clock;
    logic       i_reset;
    logic [3:0] i_sw;
    logic       i_ready;
    logic [3:0] o_sw, o_rise, o_fall, o_event;
    logic       o_valid, o_overrun;

    typedef struct {
        int         due;
        logic [3:0] sw;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] ev;
        logic       valid;
        logic       ovr;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ovr_seen = 0;

    sw_debounce #(
        .NB_SW      (4),
        .NB_COUNTER (14),
        .N_STABLE   (4)
    ) dut (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_sw      (i_sw),
        .i_ready   (i_ready),
        .o_sw      (o_sw),
        .o_rise    (o_rise),
        .o_fall    (o_fall),
        .o_valid   (o_valid),
        .o_event   (o_event),
        .o_overrun (o_overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Called on a negedge: the new value is first sampled on the next edge, o_sw updates 7 later.
    task automatic drive(input logic [3:0] v, input logic [3:0] rise, input logic [3:0] fall,
                         input logic ovr);
        exp_t e;
        e.due   = cyc + 8;
        e.sw    = v;
        e.rise  = rise;
        e.fall  = fall;
        e.ev    = v;
        e.valid = 1'b1;
        e.ovr   = ovr;
        q.push_back(e);
        i_sw = v;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_o_sw"}, 32'(o_sw), 32'h0);
        chk({tag, "_o_rise"}, 32'(o_rise), 32'h0);
        chk({tag, "_o_fall"}, 32'(o_fall), 32'h0);
        chk({tag, "_o_valid"}, 32'(o_valid), 32'h0);
        chk({tag, "_o_event"}, 32'(o_event), 32'h0);
        chk({tag, "_o_overrun"}, 32'(o_overrun), 32'h0);
    endtask

    always @(negedge clock) begin
        if (o_overrun) ovr_seen++;
    end

    always @(negedge clock) begin
        if (i_reset) begin
            while (q.size() > 0 && cyc > q[0].due) begin
                checks++;
                errors++;
                $display("FAIL missed_commit actual=none required=%0h at cycle %0d",
                         q[0].sw, q[0].due);
                void'(q.pop_front());
            end
            if ((o_rise | o_fall) != 4'b0000) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit actual=%0h required=none (cycle %0d)",
                             o_sw, cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("commit_cycle", 32'(cyc), 32'(mon_e.due));
                    chk("commit_o_sw", 32'(o_sw), 32'(mon_e.sw));
                    chk("commit_o_rise", 32'(o_rise), 32'(mon_e.rise));
                    chk("commit_o_fall", 32'(o_fall), 32'(mon_e.fall));
                    chk("commit_o_valid", 32'(o_valid), 32'(mon_e.valid));
                    chk("commit_o_event", 32'(o_event), 32'(mon_e.ev));
                    chk("commit_o_overrun", 32'(o_overrun), 32'(mon_e.ovr));
                end
            end
        end
    end

    initial begin
        i_reset = 1'b0;
        i_sw    = 4'b0000;
        i_ready = 1'b1;
        tick(3);
        chk_all_zero("reset");
        #2 i_reset = 1'b1;
        tick(3);

        // Bit0 toggling every 2 cycles never reaches N_STABLE.
        for (int i = 0; i < 6; i++) begin
            i_sw = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            tick(2);
        end
        tick(10);
        chk("bounce_o_sw", 32'(o_sw), 32'h0);
        chk("bounce_o_valid", 32'(o_valid), 32'h0);

        // Two-sample glitch.
        i_sw = 4'b0001;
        tick(2);
        i_sw = 4'b0000;
        tick(10);
        chk("glitch_o_sw", 32'(o_sw), 32'h0);
        chk("glitch_o_valid", 32'(o_valid), 32'h0);

        drive(4'b0001, 4'b0001, 4'b0000, 1'b0);
        tick(12);
        chk("consumed_o_valid", 32'(o_valid), 32'h0);
        drive(4'b0011, 4'b0010, 4'b0000, 1'b0);
        tick(12);
        drive(4'b1100, 4'b1100, 4'b0011, 1'b0);
        tick(12);
        chk("multibit_o_sw", 32'(o_sw), 32'hc);

        // Consumer stalled: second commit overwrites and flags overrun.
        i_ready = 1'b0;
        drive(4'b0001, 4'b0001, 4'b1100, 1'b0);
        tick(12);
        chk("held_o_valid", 32'(o_valid), 32'h1);
        chk("held_o_event", 32'(o_event), 32'h1);
        drive(4'b0011, 4'b0010, 4'b0000, 1'b1);
        tick(12);
        chk("overwr_o_event", 32'(o_event), 32'h3);
        chk("overwr_o_valid", 32'(o_valid), 32'h1);
        chk("overwr_ovr_count", 32'(ovr_seen), 32'h1);
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
        chk("xfer_o_valid", 32'(o_valid), 32'h0);

        // Commit coinciding with a transfer: no overrun, valid stays up.
        drive(4'b0000, 4'b0000, 4'b0011, 1'b0);
        tick(12);
        drive(4'b1000, 4'b1000, 4'b0000, 1'b0);
        tick(7);
        i_ready = 1'b1;
        tick(2);
        chk("simul_xfer_o_valid", 32'(o_valid), 32'h0);
        tick(3);

        // Reset mid-count with an event pending.
        i_ready = 1'b0;
        drive(4'b0001, 4'b0001, 4'b1000, 1'b0);
        tick(12);
        chk("pending_o_valid", 32'(o_valid), 32'h1);
        i_sw = 4'b0000;
        tick(3);
        #2 i_reset = 1'b0;
        #1 chk_all_zero("async_reset");
        tick(3);
        #2 i_reset = 1'b1;
        i_ready = 1'b1;
        tick(15);
        chk("post_reset_o_valid", 32'(o_valid), 32'h0);
        chk("post_reset_o_sw", 32'(o_sw), 32'h0);

        drive(4'b0001, 4'b0001, 4'b0000, 1'b0);
        tick(15);
        chk("queue_drained", 32'(q.size()), 32'h0);
        chk("total_overruns", 32'(ovr_seen), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
